// File: rtl/mem_store_buffer.sv
// Posted-write store buffer sitting in front of the data memory port.
// Stores are queued in a circular FIFO and retired when the port is idle.
// Loads are forwarded from the youngest matching pending store.
// Optional build macro: STORE_BUF_COALESCE_EN. When it is defined, a store
// to the youngest entry's word address merges into that entry.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   mwmem,
  input  logic                   mrmem,
  input  logic [31:0]            malu,
  input  logic [31:0]            mb,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [31:0]            mmo,
  output logic                   fwd_hit,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    waddr_q [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;

  logic [AW-1:0]    req_addr;
  logic             drain, push, coal;
  logic             match_c;
  logic [31:0]      match_data_c;
  logic [PW-1:0]    scan_idx;
  logic             load_fwd;

  // Byte offset and upper address bits carry no meaning for word stores.
  logic unused_malu;
  assign unused_malu = ^{malu[31:AW+2], malu[1:0]};

  assign req_addr = malu[AW+1:2];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;

  // A load owns the port, so retirement only happens in load-free cycles.
  assign drain     = !empty && mem_ready && !mrmem;
  assign mem_we    = drain;
  assign mem_wdata = data_q[head_q];
  assign mem_addr  = mrmem ? req_addr : waddr_q[head_q];

`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0] young_idx;
  assign young_idx = tail_q - PW'(1);
  // Merging into a head entry that leaves this cycle would lose the data.
  assign coal = mwmem && !empty && valid_q[young_idx] &&
                (waddr_q[young_idx] == req_addr) &&
                !((count_q == CW'(1)) && drain);
`else
  assign coal = 1'b0;
`endif

  assign stall = mwmem && full && !drain && !coal;
  assign push  = mwmem && !stall && !coal;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    match_c      = 1'b0;
    match_data_c = '0;
    scan_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (valid_q[scan_idx] && (waddr_q[scan_idx] == req_addr)) begin
        match_c      = 1'b1;
        match_data_c = data_q[scan_idx];
      end
    end
  end

  // A simultaneous store takes priority and the load is dropped.
  assign load_fwd = mrmem && !mwmem && match_c;
  assign fwd_hit  = load_fwd;
  assign mmo      = load_fwd ? match_data_c : mem_rdata;

  // Occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    count_d = count_q;
    case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and valid bits; reset discards every pending store.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      if (drain) begin
        head_q           <= head_q + PW'(1);
        valid_q[head_q]  <= 1'b0;
      end
      // When full, head equals tail; the set below must override the clear.
      if (push) begin
        tail_q           <= tail_q + PW'(1);
        valid_q[tail_q]  <= 1'b1;
      end
    end
  end

  // Entry payload; qualified by valid_q so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      waddr_q[tail_q] <= req_addr;
      data_q[tail_q]  <= mb;
    end else if (coal) begin
      data_q[tail_q - PW'(1)] <= mb;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model and an architectural memory image.
module tb_mem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NW    = 1 << AW;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          mwmem = 1'b0, mrmem = 1'b0, mem_ready = 1'b0;
  logic [31:0]   malu = '0, mb = '0;
  logic [31:0]   mem_rdata;
  logic          mem_we, fwd_hit, stall, empty, full;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mmo;
  logic [CW-1:0] count;

  mem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .resetn(resetn), .mwmem(mwmem), .mrmem(mrmem),
    .malu(malu), .mb(mb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mmo(mmo), .fwd_hit(fwd_hit), .stall(stall), .count(count),
    .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  // Data memory: combinational read, write on the clock edge.
  logic [31:0] tbmem [NW];
  assign mem_rdata = tbmem[mem_addr];
  always @(posedge clock) if (mem_we) tbmem[mem_addr] <= mem_wdata;

  // Reference: pending stores in program order plus the value every word
  // should have from the program's point of view.
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] arch [NW];
  bit          last_stall = 1'b0;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model, then advance.
  task automatic step();
    int            sz;
    logic [AW-1:0] a;
    bit            drn, cl, stl, hit;
    ent_t          e;
    #1;
    sz  = q.size();
    a   = malu[AW+1:2];
    drn = (sz > 0) && mem_ready && !mrmem;
    cl  = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    if (mwmem && sz > 0 && q[sz-1].a == a && !(sz == 1 && drn)) cl = 1'b1;
`endif
    stl = mwmem && (sz == DEPTH) && !drn && !cl;
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full",  32'(full),  32'(sz == DEPTH));
    chk("stall", 32'(stall), 32'(stl));
    chk("mem_we", 32'(mem_we), 32'(drn));
    if (drn) begin
      chk("drain_addr", 32'(mem_addr), 32'(q[0].a));
      chk("drain_data", mem_wdata, q[0].d);
    end
    if (mrmem) chk("load_addr", 32'(mem_addr), 32'(a));
    hit = 1'b0;
    if (mrmem && !mwmem)
      for (int i = 0; i < sz; i++) if (q[i].a == a) hit = 1'b1;
    chk("fwd_hit", 32'(fwd_hit), 32'(hit));
    if (mrmem && !mwmem) chk("load_value", mmo, arch[a]);
    else if (mrmem)      chk("ignored_load", mmo, tbmem[a]);
    last_stall = stl;
    @(posedge clock);
    if (cl) begin
      e = q[sz-1]; e.d = mb; q[sz-1] = e;
    end
    if (drn) void'(q.pop_front());
    if (mwmem && !stl && !cl) q.push_back({a, mb});
    if (mwmem && !stl) arch[a] = mb;
    @(negedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] ad, input logic [31:0] dt);
    mwmem = 1'b1; mrmem = 1'b0; malu = ad; mb = dt;
    step();
    mwmem = 1'b0;
  endtask

  task automatic drain_all();
    mwmem = 1'b0; mrmem = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) step();
    chk("drain_all_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      tbmem[i] = $urandom();
      arch[i]  = tbmem[i];
    end
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    #1;

    // Single store retires on the following cycle.
    mem_ready = 1'b1;
    store(32'h10, 32'hDEADBEEF);
    #1;
    chk("t1_we",    32'(mem_we), 32'd1);
    chk("t1_addr",  32'(mem_addr), 32'd4);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill, stall on the fifth store, then push and pop on one edge.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'(i * 4), $urandom());
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_full",  32'(full), 32'd1);
    mwmem = 1'b1; malu = 32'h3C; mb = 32'hCAFE0005;
    #1;
    chk("t2_stall", 32'(stall), 32'd1);
    step();
    step();
    mem_ready = 1'b1;
    #1;
    chk("t2_unstall", 32'(stall), 32'd0);
    chk("t2_head",    32'(mem_addr), 32'd0);
    step();
    mwmem = 1'b0;
    chk("t2_count_kept", 32'(count), 32'd4);
    drain_all();

    // Forwarding of the youngest store; miss falls through to memory.
    mem_ready = 1'b0;
    store(32'h20, 32'h11);
    store(32'h20, 32'h22);
    mrmem = 1'b1; malu = 32'h20;
    #1;
    chk("t3_hit", 32'(fwd_hit), 32'd1);
    chk("t3_mmo", mmo, 32'h22);
    step();
    malu = 32'h24;
    #1;
    chk("t3_miss", 32'(fwd_hit), 32'd0);
    chk("t3_miss_mmo", mmo, tbmem[9]);
    step();
    mrmem = 1'b0;
    drain_all();

    // Loads block retirement; entries then retire back to back.
    mem_ready = 1'b0;
    store(32'h40, 32'hA0);
    store(32'h44, 32'hA1);
    mem_ready = 1'b1; mrmem = 1'b1; malu = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_blocked", 32'(mem_we), 32'd0);
      step();
    end
    mrmem = 1'b0;
    #1;
    chk("t4_first", 32'(mem_addr), 32'd16);
    step();
    chk("t4_second_we", 32'(mem_we), 32'd1);
    chk("t4_second", 32'(mem_addr), 32'd17);
    step();
    chk("t4_empty", 32'(empty), 32'd1);

    // Asynchronous reset between edges drops pending stores.
    mem_ready = 1'b0;
    store(32'h50, 32'hB0);
    store(32'h54, 32'hB1);
    store(32'h58, 32'hB2);
    mem_ready = 1'b1;
    resetn = 1'b0;
    #1;
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_we",    32'(mem_we), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    resetn = 1'b1;
    q.delete();
    for (int i = 0; i < NW; i++) arch[i] = tbmem[i];
    mrmem = 1'b1; malu = 32'h50;
    #1;
    chk("t5_no_fwd", 32'(fwd_hit), 32'd0);
    step();
    mrmem = 1'b0;

`ifdef STORE_BUF_COALESCE_EN
    // Same-address stores merge into one entry.
    mem_ready = 1'b0;
    store(32'h30, 32'h1);
    store(32'h30, 32'h2);
    chk("t6_count", 32'(count), 32'd1);
    mem_ready = 1'b1;
    #1;
    chk("t6_data", mem_wdata, 32'h2);
    step();
`endif

    // Random traffic; a stalled store is held as the pipeline would.
    for (int n = 0; n < 500; n++) begin
      if (!last_stall) begin
        mwmem = 1'($urandom_range(0, 1));
        mrmem = ($urandom_range(0, 2) == 0);
        malu  = $urandom();
        malu[AW+1:2] = AW'($urandom_range(0, 7));
        mb    = $urandom();
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    mwmem = 1'b0; mrmem = 1'b0;
    drain_all();
    for (int w = 0; w < 8; w++) chk("final_mem", tbmem[w], arch[w]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
